// File: rtl/rv32i_pkg.sv
// Shared types for the pipeline hazard controller: memory-wait FSM states,
// register index width and the pipeline control bundle.
package rv32i_pkg;

    localparam int REG_W       = 5;
    localparam int STALL_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } mem_state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
    } pipe_ctrl_t;

    // Resolve the pipeline control word; memory stall outranks a taken
    // branch, which outranks a load-use bubble.
    function automatic pipe_ctrl_t select_ctrl(input logic mem_stall,
                                               input logic branch,
                                               input logic load_use);
        pipe_ctrl_t c;
        if (mem_stall)
            c = 7'b00000_00;
        else if (branch)
            c = 7'b11111_11;
        else if (load_use)
            c = 7'b00111_01;
        else
            c = 7'b11111_00;
        return c;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the load in ID/EX and the consumer in IF/ID.
module hazard_detect
    import rv32i_pkg::*;
(
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    output logic             load_use
);

    // x0 never carries a dependency, so a load to x0 cannot cause a hazard.
    always_comb begin
        load_use = ex_mem_read && (ex_rd != '0) &&
                   ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                    (id_use_rs2 && (id_rs2 == ex_rd)));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: data-memory wait FSM with timeout, pipeline
// enable/flush generation and a saturating stall-cycle counter.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no access in flight; mem_val starts one (stall this cycle)
// ST_WAIT  | dmem_req held, waiting for dmem_ack, wait counter running
// ST_DONE  | access completed, pipeline released for one cycle
// ST_ERROR | dmem_ack never arrived; pipeline frozen until reset
module pipe_hazard_ctrl
    import rv32i_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_val,
    input  logic                   mem_rw,
    input  logic                   dmem_ack,
    input  logic                   ex_mem_read,
    input  logic [REG_W-1:0]       ex_rd,
    input  logic [REG_W-1:0]       id_rs1,
    input  logic [REG_W-1:0]       id_rs2,
    input  logic                   id_use_rs1,
    input  logic                   id_use_rs2,
    input  logic                   ex_branch_taken,
    output logic                   pc_en,
    output logic                   ifid_en,
    output logic                   idex_en,
    output logic                   exmem_en,
    output logic                   memwb_en,
    output logic                   ifid_flush,
    output logic                   idex_flush,
    output logic                   dmem_req,
    output logic                   dmem_we,
    output logic                   mem_error,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mem_state_t       state, state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic             mem_stall;
    logic             load_use;
    pipe_ctrl_t       ctrl;

    hazard_detect u_hazard_detect (
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .load_use    (load_use)
    );

    // Next-state and memory-stall decode; ack wins over timeout in WAIT.
    always_comb begin
        state_next = state;
        mem_stall  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_val) begin
                    mem_stall  = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                mem_stall = 1'b1;
                if (dmem_ack)
                    state_next = ST_DONE;
                else if (wait_cnt == CNT_LAST)
                    state_next = ST_ERROR;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            ST_ERROR: begin
                mem_stall = 1'b1;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        ctrl = select_ctrl(mem_stall, ex_branch_taken, load_use);
    end

    assign pc_en      = ctrl.pc_en;
    assign ifid_en    = ctrl.ifid_en;
    assign idex_en    = ctrl.idex_en;
    assign exmem_en   = ctrl.exmem_en;
    assign memwb_en   = ctrl.memwb_en;
    assign ifid_flush = ctrl.ifid_flush;
    assign idex_flush = ctrl.idex_flush;

    // FSM state, wait counter, registered memory request and sticky error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            mem_error <= 1'b0;
        end else begin
            state     <= state_next;
            mem_error <= mem_error | (state_next == ST_ERROR);
            if (state == ST_WAIT && state_next == ST_WAIT)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
            if (state == ST_IDLE && state_next == ST_WAIT) begin
                dmem_req <= 1'b1;
                dmem_we  <= mem_rw;
            end else if (state_next != ST_WAIT) begin
                dmem_req <= 1'b0;
                dmem_we  <= 1'b0;
            end
        end
    end

    // Count every cycle the PC is held, saturating at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= '0;
        else if (!pc_en && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl with a behavioural reference model.
module tb_pipe_hazard_ctrl;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_val = 1'b0, mem_rw = 1'b0, dmem_ack = 1'b0;
    logic        ex_mem_read = 1'b0;
    logic [4:0]  ex_rd = '0, id_rs1 = '0, id_rs2 = '0;
    logic        id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, ex_branch_taken = 1'b0;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush;
    logic        dmem_req, dmem_we, mem_error;
    logic [15:0] stall_cnt;
    logic [6:0]  ctrl_obs;

    int n_pass  = 0;
    int n_total = 0;
    int m_stall = 0;

    always #5 clk = ~clk;

    assign ctrl_obs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};

    pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .mem_val(mem_val), .mem_rw(mem_rw), .dmem_ack(dmem_ack),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_branch_taken(ex_branch_taken),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .mem_error(mem_error), .stall_cnt(stall_cnt)
    );

    // Reference: load-use rule applied to the current inputs.
    function automatic bit model_load_use();
        return ex_mem_read && ex_rd != 0 &&
               ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    endfunction

    // Reference control word {pc,ifid,idex,exmem,memwb,ifid_flush,idex_flush}.
    function automatic logic [6:0] model_ctrl(input bit stall);
        if (stall)                 return 7'b0000000;
        if (ex_branch_taken)       return 7'b1111111;
        if (model_load_use())      return 7'b0011101;
        return 7'b1111100;
    endfunction

    task automatic clear_hazard();
        ex_mem_read = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; ex_branch_taken = 0;
    endtask

    task automatic rand_hazard();
        ex_mem_read     = 1'($urandom_range(0, 1));
        ex_rd           = 5'($urandom_range(0, 3));
        id_rs1          = 5'($urandom_range(0, 3));
        id_rs2          = 5'($urandom_range(0, 3));
        id_use_rs1      = 1'($urandom_range(0, 1));
        id_use_rs2      = 1'($urandom_range(0, 1));
        ex_branch_taken = ($urandom_range(0, 3) == 0);
    endtask

    task automatic hw_reset();
        @(posedge clk); #1;
        rst = 0; mem_val = 0; mem_rw = 0; dmem_ack = 0;
        clear_hazard();
        repeat (2) @(posedge clk);
        #1 rst = 1;
        m_stall = 0;
    endtask

    task automatic test_reset();
        logic [6:0] exp;
        rst = 0;
        clear_hazard();
        #3;
        n_total++;
        if ({dmem_req, dmem_we, mem_error} !== 3'b000) $display("FAIL reset_regs got=%b want=000", {dmem_req, dmem_we, mem_error});
        else n_pass++;
        n_total++;
        if (stall_cnt !== 16'd0) $display("FAIL reset_stall_cnt got=%0d want=0", stall_cnt);
        else n_pass++;
        exp = model_ctrl(0);
        n_total++;
        if (ctrl_obs !== exp) $display("FAIL reset_ctrl_normal got=%b want=%b", ctrl_obs, exp);
        else n_pass++;
        ex_mem_read = 1; ex_rd = 7; id_rs1 = 7; id_use_rs1 = 1;
        @(posedge clk); #1;
        exp = model_ctrl(0);
        n_total++;
        if (ctrl_obs !== exp) $display("FAIL reset_ctrl_load_use got=%b want=%b", ctrl_obs, exp);
        else n_pass++;
        n_total++;
        if (stall_cnt !== 16'd0) $display("FAIL reset_stall_hold got=%0d want=0", stall_cnt);
        else n_pass++;
        clear_hazard();
        @(posedge clk); #1 rst = 1;
        m_stall = 0;
    endtask

    // Memory accesses; first one is the directed read with ack 3 cycles after req.
    task automatic test_mem_access();
        bit rw, exp_stall, exp_req;
        int d;
        logic [6:0] exp;
        hw_reset();
        for (int t = 0; t < 12; t++) begin
            rw = (t == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            d  = (t == 0) ? 3 : $urandom_range(0, TIMEOUT - 1);
            for (int k = 0; k <= d + 3; k++) begin
                @(posedge clk); #1;
                mem_val  = (k <= d + 2);
                mem_rw   = rw;
                dmem_ack = (k == d + 1) || (k != d + 1 && k != 1 && k <= d && 0) ||
                           (k >= d + 2 && $urandom_range(0, 1) == 1);
                if (t == 0) clear_hazard(); else rand_hazard();
                exp_stall = (k <= d + 1);
                exp_req   = (k >= 1 && k <= d + 1);
                #4;
                exp = model_ctrl(exp_stall);
                n_total++;
                if (ctrl_obs !== exp) $display("FAIL mem_ctrl t=%0d k=%0d got=%b want=%b", t, k, ctrl_obs, exp);
                else n_pass++;
                n_total++;
                if ({dmem_req, dmem_we, mem_error} !== {exp_req, exp_req & rw, 1'b0})
                    $display("FAIL mem_req t=%0d k=%0d got=%b want=%b", t, k,
                             {dmem_req, dmem_we, mem_error}, {exp_req, exp_req & rw, 1'b0});
                else n_pass++;
                n_total++;
                if (stall_cnt !== 16'(m_stall)) $display("FAIL mem_stall_cnt t=%0d k=%0d got=%0d want=%0d", t, k, stall_cnt, m_stall);
                else n_pass++;
                if (exp[6] == 1'b0) m_stall++;
            end
            if (t == 0) begin
                n_total++;
                if (stall_cnt !== 16'd5) $display("FAIL read_ack3_stall_cnt got=%0d want=5", stall_cnt);
                else n_pass++;
            end
        end
        mem_val = 0; dmem_ack = 0; clear_hazard();
    endtask

    task automatic test_timeout();
        bit exp_req, exp_err;
        hw_reset();
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            mem_val  = 1;
            mem_rw   = 1;
            dmem_ack = (k >= 7);
            exp_req  = (k >= 1 && k <= TIMEOUT);
            exp_err  = (k >= TIMEOUT + 1);
            #4;
            n_total++;
            if (ctrl_obs !== 7'b0) $display("FAIL timeout_ctrl k=%0d got=%b want=0000000", k, ctrl_obs);
            else n_pass++;
            n_total++;
            if ({dmem_req, mem_error} !== {exp_req, exp_err})
                $display("FAIL timeout_req_err k=%0d got=%b want=%b", k, {dmem_req, mem_error}, {exp_req, exp_err});
            else n_pass++;
            n_total++;
            if (stall_cnt !== 16'(m_stall)) $display("FAIL timeout_stall_cnt k=%0d got=%0d want=%0d", k, stall_cnt, m_stall);
            else n_pass++;
            m_stall++;
        end
        hw_reset();
        #3;
        n_total++;
        if (mem_error !== 1'b0) $display("FAIL timeout_clear got=%b want=0", mem_error);
        else n_pass++;
    endtask

    task automatic test_load_use();
        logic [6:0] exp;
        hw_reset();
        @(posedge clk); #1;
        ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1; id_rs1 = 2; id_use_rs1 = 1;
        #4;
        exp = model_ctrl(0);
        n_total++;
        if (ctrl_obs !== exp || exp !== 7'b0011101) $display("FAIL load_use_bubble got=%b want=%b", ctrl_obs, exp);
        else n_pass++;
        @(posedge clk); #1;
        ex_mem_read = 0;
        #4;
        exp = model_ctrl(0);
        n_total++;
        if (ctrl_obs !== exp) $display("FAIL load_use_release got=%b want=%b", ctrl_obs, exp);
        else n_pass++;
        n_total++;
        if (stall_cnt !== 16'd1) $display("FAIL load_use_stall_cnt got=%0d want=1", stall_cnt);
        else n_pass++;
        clear_hazard();
    endtask

    task automatic test_branch_priority();
        hw_reset();
        @(posedge clk); #1;
        ex_mem_read = 1; ex_rd = 9; id_rs1 = 9; id_use_rs1 = 1; ex_branch_taken = 1;
        #4;
        n_total++;
        if (ctrl_obs !== 7'b1111111) $display("FAIL branch_over_load_use got=%b want=1111111", ctrl_obs);
        else n_pass++;
        clear_hazard();
    endtask

    task automatic test_rd_zero();
        hw_reset();
        @(posedge clk); #1;
        ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1; id_rs2 = 0; id_use_rs2 = 1;
        #4;
        n_total++;
        if (ctrl_obs !== 7'b1111100) $display("FAIL rd_zero_no_stall got=%b want=1111100", ctrl_obs);
        else n_pass++;
        clear_hazard();
    endtask

    task automatic test_random_hazards();
        logic [6:0] exp;
        hw_reset();
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            rand_hazard();
            dmem_ack = 1'($urandom_range(0, 1));
            #4;
            exp = model_ctrl(0);
            n_total++;
            if (ctrl_obs !== exp) $display("FAIL rand_ctrl i=%0d got=%b want=%b", i, ctrl_obs, exp);
            else n_pass++;
            n_total++;
            if (dmem_req !== 1'b0 || stall_cnt !== 16'(m_stall))
                $display("FAIL rand_state i=%0d req=%b cnt=%0d want req=0 cnt=%0d", i, dmem_req, stall_cnt, m_stall);
            else n_pass++;
            if (exp[6] == 1'b0) m_stall++;
        end
        dmem_ack = 0; clear_hazard();
    endtask

    task automatic test_reset_mid_wait();
        hw_reset();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            mem_val = 1; mem_rw = 1;
        end
        #4;
        n_total++;
        if ({dmem_req, dmem_we} !== 2'b11) $display("FAIL mid_wait_req got=%b want=11", {dmem_req, dmem_we});
        else n_pass++;
        #2;
        rst = 0; mem_val = 0;
        #1;
        n_total++;
        if ({dmem_req, dmem_we, stall_cnt} !== {2'b00, 16'd0})
            $display("FAIL mid_wait_reset got req=%b we=%b cnt=%0d want 0 0 0", dmem_req, dmem_we, stall_cnt);
        else n_pass++;
        n_total++;
        if (ctrl_obs !== 7'b1111100) $display("FAIL mid_wait_reset_ctrl got=%b want=1111100", ctrl_obs);
        else n_pass++;
        @(posedge clk); #1 rst = 1;
        m_stall = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            dmem_ack = (k == 0);
            #4;
            n_total++;
            if (dmem_req !== 1'b0 || ctrl_obs !== 7'b1111100 || stall_cnt !== 16'd0)
                $display("FAIL after_reset k=%0d req=%b ctrl=%b cnt=%0d want 0 1111100 0", k, dmem_req, ctrl_obs, stall_cnt);
            else n_pass++;
        end
        dmem_ack = 0;
    endtask

    initial begin
        test_reset();
        test_mem_access();
        test_timeout();
        test_load_use();
        test_branch_priority();
        test_rd_zero();
        test_random_hazards();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
